// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter/sequencer sharing one 32K x 8 RAM port.
// Optional grant locking for bursts is enabled with `define RAM_ARB_LOCK_EN.
module ram_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_datain,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dataout,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic any_req;
  logic both_req;
  logic pick;
  logic grant_go;
  logic gnt;
  logic last_grant;
  logic we_q;

  assign any_req  = m0_req | m1_req;
  assign both_req = m0_req & m1_req;

`ifdef RAM_ARB_LOCK_EN
  logic [1:0] lock_q;
  logic [1:0] lock_n;

  // a locked master that is still requesting overrides round-robin
  always_comb begin
    pick = m1_req;
    if (lock_q[0] && m0_req)
      pick = 1'b0;
    else if (lock_q[1] && m1_req)
      pick = 1'b1;
    else if (both_req)
      pick = ~last_grant;
  end

  always_comb begin
    lock_n = lock_q;
    if (state == IDLE) begin
      lock_n = 2'b00;
      if (any_req) begin
        if (pick)
          lock_n[1] = m1_lock;
        else
          lock_n[0] = m0_lock;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lock_q <= 2'b00;
    else
      lock_q <= lock_n;
  end
`else
  logic unused_lock;

  assign unused_lock = m0_lock ^ m1_lock;

  always_comb begin
    pick = m1_req;
    if (both_req)
      pick = ~last_grant;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    grant_go = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          grant_go = 1'b1;
          state_n  = SERVE;
        end
      end
      SERVE:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // write strobe is gated by state so reset removes it at once
  assign ram_we = (state == SERVE) & we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= 1'b0;
      last_grant  <= 1'b1;
      we_q        <= 1'b0;
      ram_address <= '0;
      ram_datain  <= '0;
    end else if (grant_go) begin
      gnt        <= pick;
      last_grant <= pick;
      if (pick) begin
        we_q        <= m1_we;
        ram_address <= m1_addr;
        ram_datain  <= m1_wdata;
      end else begin
        we_q        <= m0_we;
        ram_address <= m0_addr;
        ram_datain  <= m0_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      busy     <= 1'b0;
    end else begin
      busy   <= (state_n != IDLE);
      m0_ack <= (state == SERVE) & ~gnt;
      m1_ack <= (state == SERVE) & gnt;
      if ((state == SERVE) && !we_q) begin
        if (gnt)
          m1_rdata <= ram_dataout;
        else
          m0_rdata <= ram_dataout;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter against a behavioural RAM.
// Lock expectations follow `define RAM_ARB_LOCK_EN.
module tb_ram_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m0_lock, m0_ack;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_ack;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_datain, ram_dataout;
  logic          ram_we, busy;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en)
      mem[pl_addr] <= pl_data;
    else if (ram_we)
      mem[ram_address] <= ram_datain;
  end

  assign ram_dataout = mem[ram_address];

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_address(ram_address), .ram_datain(ram_datain),
    .ram_we(ram_we), .ram_dataout(ram_dataout), .busy(busy)
  );

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_lock = 0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({busy, ram_we, m0_ack, m1_ack} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctl got %b want 0000", {busy, ram_we, m0_ack, m1_ack});
    end
    tests++;
    if (ram_address !== '0) begin
      fails++;
      $display("FAIL reset_addr got %h want 0000", ram_address);
    end
    tests++;
    if (ram_datain !== '0) begin
      fails++;
      $display("FAIL reset_datain got %h want 00", ram_datain);
    end
    tests++;
    if (m0_rdata !== '0 || m1_rdata !== '0) begin
      fails++;
      $display("FAIL reset_rdata got %h/%h want 00/00", m0_rdata, m1_rdata);
    end
  endtask

  task automatic test_write();
    int we_cnt = 0;
    int ack_cnt = 0;
    int ack_at = -1;
    m0_req = 1; m0_we = 1; m0_addr = 15'h0010; m0_wdata = 8'h5A;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (ram_we) begin
        we_cnt++;
        tests++;
        if (ram_address !== 15'h0010) begin
          fails++;
          $display("FAIL wr_addr got %h want 0010", ram_address);
        end
      end
      if (m0_ack) begin
        ack_cnt++;
        if (ack_at < 0) ack_at = i;
        m0_req = 0; m0_we = 0;
      end
    end
    tests++;
    if (we_cnt != 1) begin
      fails++;
      $display("FAIL wr_we_cycles got %0d want 1", we_cnt);
    end
    tests++;
    if (ack_at != 2 || ack_cnt != 1) begin
      fails++;
      $display("FAIL wr_ack got at=%0d n=%0d want at=2 n=1", ack_at, ack_cnt);
    end
    tests++;
    if (m0_rdata !== 8'h00) begin
      fails++;
      $display("FAIL wr_rdata got %h want 00", m0_rdata);
    end
    tests++;
    if (mem[15'h0010] !== 8'h5A) begin
      fails++;
      $display("FAIL wr_mem got %h want 5a", mem[15'h0010]);
    end
  endtask

  task automatic test_read_m1();
    int we_cnt = 0;
    int ack_at = -1;
    logic [DW-1:0] got = '0;
    m1_req = 1; m1_we = 0; m1_addr = 15'h0010;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (ram_we) we_cnt++;
      if (m1_ack) begin
        if (ack_at < 0) begin
          ack_at = i;
          got = m1_rdata;
        end
        m1_req = 0;
      end
    end
    tests++;
    if (ack_at != 2) begin
      fails++;
      $display("FAIL rd_ack_at got %0d want 2", ack_at);
    end
    tests++;
    if (got !== 8'h5A) begin
      fails++;
      $display("FAIL rd_data got %h want 5a", got);
    end
    tests++;
    if (we_cnt != 0) begin
      fails++;
      $display("FAIL rd_we got %0d want 0", we_cnt);
    end
    tests++;
    if (m0_rdata !== 8'h00) begin
      fails++;
      $display("FAIL rd_m0_rdata got %h want 00", m0_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int m0_left = 2;
    int m1_left = 2;
    int n = 0;
    int overlap = 0;
    int t [4];
    logic [3:0] ord = '0;
    do_reset();
    preload(15'h0000, 8'h11);
    preload(15'h0001, 8'h22);
    m0_req = 1; m0_addr = 15'h0000;
    m1_req = 1; m1_addr = 15'h0001;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (m0_ack && m1_ack) overlap++;
      if (m0_ack) begin
        if (n < 4) t[n] = i;
        n++;
        ord = {ord[2:0], 1'b0};
        tests++;
        if (m0_rdata !== 8'h11) begin
          fails++;
          $display("FAIL b2b_m0_data got %h want 11", m0_rdata);
        end
        m0_left--;
        if (m0_left == 0) m0_req = 0;
      end
      if (m1_ack) begin
        if (n < 4) t[n] = i;
        n++;
        ord = {ord[2:0], 1'b1};
        tests++;
        if (m1_rdata !== 8'h22) begin
          fails++;
          $display("FAIL b2b_m1_data got %h want 22", m1_rdata);
        end
        m1_left--;
        if (m1_left == 0) m1_req = 0;
      end
    end
    tests++;
    if (n != 4 || ord !== 4'b0101) begin
      fails++;
      $display("FAIL b2b_order got n=%0d ord=%b want n=4 ord=0101", n, ord);
    end
    tests++;
    if (overlap != 0) begin
      fails++;
      $display("FAIL b2b_overlap got %0d want 0", overlap);
    end
    if (n == 4) begin
      tests++;
      if (t[0] != 2) begin
        fails++;
        $display("FAIL b2b_first_ack got %0d want 2", t[0]);
      end
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (t[k+1] - t[k] != 3) begin
          fails++;
          $display("FAIL b2b_spacing got %0d want 3", t[k+1] - t[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    m1_req = 1; m1_we = 1; m1_addr = 15'h7FFF; m1_wdata = 8'hEE;
    @(negedge clk);
    tests++;
    if (ram_we !== 1'b1 || ram_address !== 15'h7FFF || busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_serve got we=%b a=%h busy=%b want 1/7fff/1",
               ram_we, ram_address, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (ram_we !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_async got we=%b busy=%b want 0/0", ram_we, busy);
    end
    tests++;
    if ({ram_address, ram_datain, m0_rdata, m1_rdata, m0_ack, m1_ack} !== '0) begin
      fails++;
      $display("FAIL mid_outputs got a=%h d=%h r0=%h r1=%h k=%b%b want 0",
               ram_address, ram_datain, m0_rdata, m1_rdata, m0_ack, m1_ack);
    end
    m1_req = 0; m1_we = 0;
    repeat (2) begin
      @(negedge clk);
      if (m1_ack) acks++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (m1_ack || m0_ack) acks++;
    end
    tests++;
    if (acks != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_no_ack got acks=%0d busy=%b want 0/0", acks, busy);
    end
  endtask

  task automatic test_lock();
    int m0_left = 3;
    int m1_left = 3;
    int n = 0;
    int k1 = 0;
    logic [5:0] ord = '0;
    logic [5:0] exp_ord;
`ifdef RAM_ARB_LOCK_EN
    exp_ord = 6'b111000;
`else
    exp_ord = 6'b101010;
`endif
    do_reset();
    m1_req = 1; m1_we = 1; m1_lock = 1;
    m1_addr = 15'h0100; m1_wdata = 8'hA0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        m0_req = 1; m0_we = 0; m0_addr = 15'h0000;
      end
      if (m0_ack) begin
        n++;
        ord = {ord[4:0], 1'b0};
        m0_left--;
        if (m0_left == 0) m0_req = 0;
      end
      if (m1_ack) begin
        n++;
        ord = {ord[4:0], 1'b1};
        k1++;
        m1_left--;
        if (m1_left == 0) begin
          m1_req = 0; m1_we = 0; m1_lock = 0;
        end else begin
          m1_addr = 15'h0100 + 15'(k1);
          m1_wdata = 8'hA0 + 8'(k1);
        end
      end
      if (m0_left == 0 && m1_left == 0) break;
    end
    tests++;
    if (n != 6 || ord !== exp_ord) begin
      fails++;
      $display("FAIL lock_order got n=%0d ord=%b want n=6 ord=%b", n, ord, exp_ord);
    end
    tests++;
    if ({mem[15'h0100], mem[15'h0101], mem[15'h0102]} !== 24'hA0A1A2) begin
      fails++;
      $display("FAIL lock_mem got %h%h%h want a0a1a2",
               mem[15'h0100], mem[15'h0101], mem[15'h0102]);
    end
    idle_inputs();
  endtask

  task automatic test_boundary();
    int n = 0;
    @(negedge clk);
    preload(15'h7FFF, 8'hC3);
    preload(15'h0000, 8'h3C);
    m0_req = 1; m0_we = 0; m0_addr = 15'h7FFF;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1 || i == 4) begin
        tests++;
        if (ram_address !== (i == 1 ? 15'h7FFF : 15'h0000)) begin
          fails++;
          $display("FAIL bnd_addr%0d got %h", i, ram_address);
        end
      end
      if (m0_ack) begin
        tests++;
        if (m0_rdata !== (n == 0 ? 8'hC3 : 8'h3C)) begin
          fails++;
          $display("FAIL bnd_data%0d got %h want %h", n, m0_rdata,
                   (n == 0 ? 8'hC3 : 8'h3C));
        end
        n++;
        if (n == 1) m0_addr = 15'h0000;
        else m0_req = 0;
      end
    end
    tests++;
    if (n != 2) begin
      fails++;
      $display("FAIL bnd_acks got %0d want 2", n);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_write();
    test_read_m1();
    test_back_to_back();
    test_reset_mid();
    test_lock();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer for the 32K x 8 CPU RAM (asynchronous read, write on rising `clk` when `we` is high). It shares the single RAM port between master 0 (CPU core) and master 1 (loader/DMA). A three-state FSM arbitrates round-robin, drives the RAM address, data and write strobe for one cycle, registers read data, and returns a one-cycle acknowledge.

## Interface
Parameters:
- `ADDR_W`, 15, RAM address width (32768 bytes)
- `DATA_W`, 8, RAM data width

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock, rising edge
- `rst_n` input 1: asynchronous active-low reset
- `m0_req` input 1: master 0 access request; held stable until `m0_ack`
- `m0_we` input 1: master 0 write (1) / read (0)
- `m0_addr` input ADDR_W: master 0 address
- `m0_wdata` input DATA_W: master 0 write data
- `m0_lock` input 1: master 0 keep-grant hint (used only with `RAM_ARB_LOCK_EN`)
- `m0_ack` output 1: one-cycle completion pulse for master 0
- `m0_rdata` output DATA_W: master 0 read data, valid while `m0_ack`=1
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_lock`, `m1_ack`, `m1_rdata`: identical set for master 1
- `ram_address` output ADDR_W: to RAM `address`
- `ram_datain` output DATA_W: to RAM `datain`
- `ram_we` output 1: to RAM `we`
- `ram_dataout` input DATA_W: from RAM `dataout` (combinational read)
- `busy` output 1: high whenever the FSM is not in IDLE

## Operation
- FSM states: IDLE, SERVE, DONE.
- IDLE: if neither request is high, stay. If exactly one is high, grant it. If both are high, grant the master not granted last (`last_grant` register). Latch the grantee's `we`, `addr` and `wdata` into `ram_address`, `ram_datain` and an internal `we_q`. Set `last_grant`. Go to SERVE.
- SERVE: `ram_we` = `we_q`. `ram_address` and `ram_datain` hold the latched values. At the closing edge, the RAM commits the write, or `ram_dataout` is captured into the grantee's `rdata` register. Go to DONE.
- DONE: the grantee's `ack`=1 for exactly this cycle. Requests are not sampled. Go to IDLE.
- `ram_we` is 1 only in SERVE of a write. It is never 1 in IDLE or DONE.
- `mX_rdata` holds its last captured value until the next read by that master. For writes, `mX_rdata` is unchanged.
- A requester may drop `req` or present a new request in the cycle after it samples `ack`. Changing `we`, `addr` or `wdata` while waiting, before the grant, is allowed. Once granted, changes are ignored.
- Reset values: state IDLE, `last_grant`=1 (so master 0 wins the first tie), `ram_we`=0, `ram_address`=0, `ram_datain`=0, `m0_ack`=`m1_ack`=0, `m0_rdata`=`m1_rdata`=0, `busy`=0, lock flag 0.
- Reset mid-operation: `ram_we` drops asynchronously with `rst_n`. The in-flight access is abandoned and no `ack` is issued. A write in SERVE is not guaranteed to commit.

## Timing
- Access latency: request sampled at edge E0 (IDLE), then `ram_we`/address driven in cycle E0..E1 (SERVE), then `ack` and `rdata` valid in cycle E1..E2 (DONE).
- Three cycles per access. Maximum throughput is one access every 3 cycles.
- Back-to-back with both masters requesting continuously: grants alternate m0, m1, m0, …
- Combinational read path: `ram_dataout` must settle within SERVE. There is no path from `ram_dataout` to any output other than through the `rdata` registers.
- `busy` is registered and equals (state != IDLE).

## Configuration
- Macro `RAM_ARB_LOCK_EN`.
- Defined:
  - If the grantee's `lock` is 1 when granted in IDLE, a lock flag is set for that master.
  - At the next IDLE arbitration, a locked master that requests wins regardless of `last_grant`.
  - The flag clears when that master is granted with `lock`=0, or when it does not request in IDLE.
  - This gives uninterrupted bursts, such as program loading.
- Not defined: `m0_lock`/`m1_lock` are ignored and no lock flag is synthesized. Arbitration is pure round-robin.

## Test plan
- Reset, then m0 writes 0x5A to 0x0010 -> `ram_we`=1 for exactly one cycle with `ram_address`=0x0010; `m0_ack` pulses 2 cycles after request sampled; `m0_rdata` stays 0x00.
- m1 reads 0x0010 after the above -> `m1_ack` in DONE with `m1_rdata`=0x5A; `ram_we` stays 0 throughout.
- Both masters hold read requests (m0 addr 0x0000, m1 addr 0x0001) for 4 accesses from reset -> grant order m0, m1, m0, m1; acks 3 cycles apart; no overlapping acks.
- Assert `rst_n`=0 during SERVE of an m1 write to 0x7FFF -> `ram_we` drops immediately, no `m1_ack`, all outputs at reset values, `busy`=0.
- With `RAM_ARB_LOCK_EN`: m1 holds `lock`=1 for 3 writes to 0x0100..0x0102 while m0 requests continuously -> three consecutive m1 grants, then m0 granted after m1 drops `lock`. Without the macro, the same stimulus alternates m1, m0, m1.
- Boundary: m0 read at 0x7FFF, then at 0x0000 -> correct data for both; `ram_address` follows exactly with no wrap artefact.
